sr_latch_bank: RTL and testbench
================================

# sr_latch_bank

Parametrised, clocked bank of WIDTH independent set/reset latch channels with active-low set and reset inputs, the synchronous successor to the gate-level NAND SR latch. Each channel synchronises and debounces its inputs. It resolves the simultaneous set-and-reset condition according to a configurable mode and flags that condition in a sticky error bit. The bank sits between raw asynchronous control or status lines and synchronous logic that needs clean, glitch-free state bits.

## Interface
- WIDTH, 8: number of channels (≥1)
- FILTER, 2: consecutive synchronised samples a command must hold before it acts (≥1; 1 = no debounce)
- MODE, 0: resolution when both inputs are active. 0 = set-dominant, 1 = reset-dominant, 2 = hold, 3 = toggle
- INIT, 0: reset value of every q bit (0 or 1)

- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- sbar  input  WIDTH  per-channel set, active-low, asynchronous to clk
- rbar  input  WIDTH  per-channel reset, active-low, asynchronous to clk
- clr_err  input  1  synchronous clear of all err bits
- q  output  WIDTH  latch state
- qbar  output  WIDTH  always ~q
- err  output  WIDTH  sticky; set when a both-active command is qualified on that channel
- chg  output  WIDTH  one-cycle pulse when q changes on that channel

## Operation
- Per channel, the command is {s,r} = {~sbar, ~rbar}.
- The command passes through a 2-flop synchroniser. Reset value of both flops: inactive (sbar=rbar=1).
- Debounce uses a candidate register cand (2 bits) and a counter cnt (0..FILTER).
  - If the synchronised command ≠ cand: cand ← command, cnt ← 1.
  - Else, if cnt < FILTER: cnt ← cnt+1.
  - Saturates at FILTER.
- The qualify pulse is asserted in the cycle in which cnt becomes FILTER. It also fires when FILTER=1 and cand changes.
- Commands act only on the qualify pulse, not continuously:
  - 10 (set): q ← 1
  - 01 (reset): q ← 0
  - 00: no change
  - 11: per MODE. 0 → q ← 1; 1 → q ← 0; 2 → no change; 3 → q ← ~q, once per qualification.
  - 11 in any mode also sets err.
- A command held indefinitely fires exactly once. A command must return to a different value and re-qualify before it fires again.
- A glitch shorter than FILTER synchronised samples never fires. cand follows the glitch and then returns, and the counter restarts each time.
- err: set by a qualified 11. Cleared by clr_err. If clr_err and a new qualified 11 occur in the same cycle, err = 1.
- chg is registered and asserted for exactly one cycle when q changes value. A qualified command that leaves q unchanged gives chg = 0.
- Channels are fully independent; no cross-channel priority.

## Timing
- Reset (rst_n low, asynchronous):
  - q = {WIDTH{INIT}}, qbar = ~q, err = 0, chg = 0
  - synchronisers inactive, cand = 00, cnt = FILTER (nothing pending)
- Reset asserted mid-debounce discards the pending command. After release, an input still held active re-qualifies from scratch.
- Latency: let edge k be the first rising edge that samples a new stable input level. Then q updates on edge k+FILTER+2, and chg pulses during the following cycle.
  - FILTER=1: 3 edges
  - FILTER=2: 4 edges
- The first edge after rst_n deasserts obeys the same latency rule; there are no special-case early updates.
- qbar is combinational from q and has no extra latency.
- cnt width is clog2(FILTER+1); cnt never wraps.

## Test plan
- Reset and basic set/reset: INIT=0, FILTER=2, WIDTH=8. Reset → q=00, qbar=FF, err=00. Drive sbar[3]=0 held → q[3]=1 on the 4th edge, chg[3] one-cycle pulse. Release sbar[3]; drive rbar[3]=0 → q[3]=0 after 4 edges.
- Glitch rejection: FILTER=3. sbar[0] low for 2 clock cycles, then high → q[0] stays 0, chg stays 0. Held low for 3+ cycles → q[0]=1 on the 5th edge.
- Simultaneous set and reset per mode, with sbar[1]=rbar[1]=0 held and q[1]=0 initially:
  - MODE 0 → q[1]=1
  - MODE 1 → q[1]=0, no chg
  - MODE 2 → q[1] unchanged
  - MODE 3 → q[1]=1 exactly once while held; release to 00, reassert 11 → q[1]=0
  - err[1]=1 in every mode
- err clear: after err[1]=1, pulse clr_err → err=00. clr_err in the same cycle as a new qualified 11 → err[1] stays 1.
- Reset mid-operation: assert rst_n=0 one cycle before a set on channel 5 would qualify → q[5]=INIT. Keep sbar[5] low through reset release → q[5]=1 exactly FILTER+2 edges after the first post-reset sampling edge.
- Independence: set channels 0, 2, 7 and reset channel 2 with staggered timing → each channel's q matches its own stimulus alone. INIT=1 build: reset → q=FF.

Source files
------------

// File: rtl/sr_latch_bank_if.sv
// ============================================================================
// Module      : sr_latch_bank_if
// Description : Channel bus of the SR latch bank: raw set/reset lines in,
//               clean latch state, error and change flags out.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface sr_latch_bank_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sbar;
  logic [WIDTH-1:0] rbar;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] err;
  logic [WIDTH-1:0] chg;

  modport master (
    output sbar, rbar, clr_err,
    input  q, qbar, err, chg
  );

  modport slave (
    input  sbar, rbar, clr_err,
    output q, qbar, err, chg
  );
endinterface

`default_nettype wire

// File: rtl/sr_latch_bank.sv
// ============================================================================
// Module      : sr_latch_bank
// Description : Bank of synchronised, debounced set/reset latches with
//               configurable both-active resolution and sticky error flags.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sr_latch_bank #(
  parameter int WIDTH  = 8,
  parameter int FILTER = 2,
  parameter int MODE   = 0,
  parameter int INIT   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  sr_latch_bank_if.slave      bus
);

  localparam int                 c_CNT_W = $clog2(FILTER + 1);
  localparam logic [c_CNT_W-1:0] c_FILT  = c_CNT_W'(FILTER);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(FILTER - 1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_err;
  logic [WIDTH-1:0] w_chg;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [1:0]         w_raw;
    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [1:0]         r_cand;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_qual;
    logic [1:0]         r_cmd;
    logic               r_q;
    logic               r_err;
    logic               r_chg;
    logic               w_new;
    logic               w_fire;
    logic               w_q_nxt;
    logic               w_err_set;

    // Command encoding is {set, reset}, both active-high.
    assign w_raw = {~bus.sbar[i], ~bus.rbar[i]};

    always_comb begin
      w_new  = (r_sync2 != r_cand);
      w_fire = w_new ? (FILTER == 1) : (r_cnt == c_LAST);
    end

    always_comb begin
      w_q_nxt   = r_q;
      w_err_set = 1'b0;
      if (r_qual) begin
        case (r_cmd)
          2'b10: w_q_nxt = 1'b1;
          2'b01: w_q_nxt = 1'b0;
          2'b11: begin
            w_err_set = 1'b1;
            case (MODE)
              0:       w_q_nxt = 1'b1;
              1:       w_q_nxt = 1'b0;
              3:       w_q_nxt = ~r_q;
              default: w_q_nxt = r_q;
            endcase
          end
          default: w_q_nxt = r_q;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= 2'b00;
        r_sync2 <= 2'b00;
        r_cand  <= 2'b00;
        r_cnt   <= c_FILT;
        r_qual  <= 1'b0;
        r_cmd   <= 2'b00;
        r_q     <= 1'(INIT);
        r_err   <= 1'b0;
        r_chg   <= 1'b0;
      end else begin
        r_sync1 <= w_raw;
        r_sync2 <= r_sync1;
        if (w_new) begin
          r_cand <= r_sync2;
          r_cnt  <= c_CNT_W'(1);
        end else if (r_cnt < c_FILT) begin
          r_cnt <= r_cnt + 1'b1;
        end
        // The qualified command is applied one edge later, giving k+FILTER+2.
        r_qual <= w_fire;
        r_cmd  <= r_sync2;
        r_q    <= w_q_nxt;
        r_chg  <= (w_q_nxt != r_q);
        r_err  <= w_err_set | (r_err & ~bus.clr_err);
      end
    end

    assign w_q[i]   = r_q;
    assign w_err[i] = r_err;
    assign w_chg[i] = r_chg;
  end

  assign bus.q    = w_q;
  assign bus.qbar = ~w_q;
  assign bus.err  = w_err;
  assign bus.chg  = w_chg;

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_bank.sv
// ============================================================================
// Module      : tb_sr_latch_bank
// Description : Scoreboard bench for sr_latch_bank over five parameter builds.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sr_latch_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   edge_cnt = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // d0: F2 M0 I0, d1: F3 M1, d2: F2 M2, d3: F1 M3, d4: F2 M0 I1
  sr_latch_bank_if #(.WIDTH(8)) if0 ();
  sr_latch_bank_if #(.WIDTH(8)) if1 ();
  sr_latch_bank_if #(.WIDTH(8)) if2 ();
  sr_latch_bank_if #(.WIDTH(8)) if3 ();
  sr_latch_bank_if #(.WIDTH(8)) if4 ();

  sr_latch_bank #(.WIDTH(8), .FILTER(2), .MODE(0), .INIT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  sr_latch_bank #(.WIDTH(8), .FILTER(3), .MODE(1), .INIT(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  sr_latch_bank #(.WIDTH(8), .FILTER(2), .MODE(2), .INIT(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  sr_latch_bank #(.WIDTH(8), .FILTER(1), .MODE(3), .INIT(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  sr_latch_bank #(.WIDTH(8), .FILTER(2), .MODE(0), .INIT(1)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  logic [7:0] aq [5];
  logic [7:0] aqb[5];
  logic [7:0] ae [5];
  logic [7:0] ac [5];
  assign aq[0] = if0.q;  assign aqb[0] = if0.qbar; assign ae[0] = if0.err; assign ac[0] = if0.chg;
  assign aq[1] = if1.q;  assign aqb[1] = if1.qbar; assign ae[1] = if1.err; assign ac[1] = if1.chg;
  assign aq[2] = if2.q;  assign aqb[2] = if2.qbar; assign ae[2] = if2.err; assign ac[2] = if2.chg;
  assign aq[3] = if3.q;  assign aqb[3] = if3.qbar; assign ae[3] = if3.err; assign ac[3] = if3.chg;
  assign aq[4] = if4.q;  assign aqb[4] = if4.qbar; assign ae[4] = if4.err; assign ac[4] = if4.chg;

  localparam int K_Q = 0, K_ERR = 1, K_CHG = 2, K_QB = 3;

  typedef struct {
    int         cyc;
    int         dut;
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];

  task automatic ex(input int c, input int d, input int k, input logic [7:0] v, input string n);
    exp_t e;
    e.cyc = c; e.dut = d; e.kind = k; e.exp = v; e.name = n;
    sb.push_back(e);
  endtask

  function automatic logic [7:0] actual(input int d, input int k);
    case (k)
      K_Q:     return aq[d];
      K_ERR:   return ae[d];
      K_CHG:   return ac[d];
      default: return aqb[d];
    endcase
  endfunction

  // Monitor: after each edge, retire every expectation due for that edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= edge_cnt) begin
        checks++;
        if (sb[i].cyc < edge_cnt) begin
          failures++;
          $display("FAIL %s missed check at edge %0d (now %0d)", sb[i].name, sb[i].cyc, edge_cnt);
        end else if (actual(sb[i].dut, sb[i].kind) !== sb[i].exp) begin
          failures++;
          $display("FAIL %s edge=%0d dut=%0d actual=%02h expected=%02h",
                   sb[i].name, edge_cnt, sb[i].dut, actual(sb[i].dut, sb[i].kind), sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  int e;

  initial begin
    if0.sbar = '1; if0.rbar = '1; if0.clr_err = 1'b0;
    if1.sbar = '1; if1.rbar = '1; if1.clr_err = 1'b0;
    if2.sbar = '1; if2.rbar = '1; if2.clr_err = 1'b0;
    if3.sbar = '1; if3.rbar = '1; if3.clr_err = 1'b0;
    if4.sbar = '1; if4.rbar = '1; if4.clr_err = 1'b0;

    // Reset state
    tick(2); e = edge_cnt;
    ex(e, 0, K_Q, 8'h00, "rst_q");
    ex(e, 0, K_QB, 8'hFF, "rst_qbar");
    ex(e, 0, K_ERR, 8'h00, "rst_err");
    ex(e, 0, K_CHG, 8'h00, "rst_chg");
    ex(e, 4, K_Q, 8'hFF, "rst_q_init1");
    ex(e, 4, K_QB, 8'h00, "rst_qbar_init1");
    rst_n = 1'b1;
    tick(3);

    // Basic set then reset on channel 3 (FILTER=2)
    e = edge_cnt; if0.sbar[3] = 1'b0;
    ex(e + 4, 0, K_Q, 8'h00, "set3_early");
    ex(e + 5, 0, K_Q, 8'h08, "set3_q");
    ex(e + 5, 0, K_QB, 8'hF7, "set3_qbar");
    ex(e + 5, 0, K_CHG, 8'h08, "set3_chg");
    ex(e + 6, 0, K_CHG, 8'h00, "set3_chg_end");
    ex(e + 7, 0, K_Q, 8'h08, "set3_hold");
    tick(8); if0.sbar[3] = 1'b1;
    tick(5);
    e = edge_cnt; if0.rbar[3] = 1'b0;
    ex(e + 4, 0, K_Q, 8'h08, "rst3_early");
    ex(e + 5, 0, K_Q, 8'h00, "rst3_q");
    ex(e + 5, 0, K_CHG, 8'h08, "rst3_chg");
    tick(7); if0.rbar[3] = 1'b1;
    tick(5);

    // Glitch rejection (FILTER=3)
    e = edge_cnt; if1.sbar[0] = 1'b0;
    tick(2); if1.sbar[0] = 1'b1;
    ex(e + 6, 1, K_Q, 8'h00, "glitch_q");
    ex(e + 6, 1, K_CHG, 8'h00, "glitch_chg");
    ex(e + 9, 1, K_Q, 8'h00, "glitch_q_late");
    tick(10);
    e = edge_cnt; if1.sbar[0] = 1'b0;
    ex(e + 5, 1, K_Q, 8'h00, "f3_early");
    ex(e + 6, 1, K_Q, 8'h01, "f3_q");
    ex(e + 6, 1, K_CHG, 8'h01, "f3_chg");
    tick(9); if1.sbar[0] = 1'b1;
    tick(6);

    // Both-active per mode on channel 1
    e = edge_cnt;
    if0.sbar[1] = 1'b0; if0.rbar[1] = 1'b0;
    if1.sbar[1] = 1'b0; if1.rbar[1] = 1'b0;
    if2.sbar[1] = 1'b0; if2.rbar[1] = 1'b0;
    if3.sbar[1] = 1'b0; if3.rbar[1] = 1'b0;
    ex(e + 5, 0, K_Q, 8'h02, "m0_q");
    ex(e + 5, 0, K_CHG, 8'h02, "m0_chg");
    ex(e + 5, 0, K_ERR, 8'h02, "m0_err");
    ex(e + 5, 1, K_ERR, 8'h00, "m1_err_early");
    ex(e + 6, 1, K_Q, 8'h01, "m1_q");
    ex(e + 6, 1, K_CHG, 8'h00, "m1_chg");
    ex(e + 6, 1, K_ERR, 8'h02, "m1_err");
    ex(e + 5, 2, K_Q, 8'h00, "m2_q");
    ex(e + 5, 2, K_CHG, 8'h00, "m2_chg");
    ex(e + 5, 2, K_ERR, 8'h02, "m2_err");
    ex(e + 3, 3, K_Q, 8'h00, "m3_early");
    ex(e + 4, 3, K_Q, 8'h02, "m3_q");
    ex(e + 4, 3, K_CHG, 8'h02, "m3_chg");
    ex(e + 4, 3, K_ERR, 8'h02, "m3_err");
    ex(e + 5, 3, K_CHG, 8'h00, "m3_chg_end");
    ex(e + 10, 3, K_Q, 8'h02, "m3_once");
    tick(12);
    if0.sbar[1] = 1'b1; if0.rbar[1] = 1'b1;
    if1.sbar[1] = 1'b1; if1.rbar[1] = 1'b1;
    if2.sbar[1] = 1'b1; if2.rbar[1] = 1'b1;
    if3.sbar[1] = 1'b1; if3.rbar[1] = 1'b1;
    tick(6);
    e = edge_cnt; if3.sbar[1] = 1'b0; if3.rbar[1] = 1'b0;
    ex(e + 3, 3, K_Q, 8'h02, "m3_re_early");
    ex(e + 4, 3, K_Q, 8'h00, "m3_toggle_back");
    ex(e + 4, 3, K_CHG, 8'h02, "m3_re_chg");
    tick(6); if3.sbar[1] = 1'b1; if3.rbar[1] = 1'b1;
    tick(4);

    // err clear, then clear coinciding with a new qualified 11
    e = edge_cnt; if0.clr_err = 1'b1;
    ex(e, 0, K_ERR, 8'h02, "err_before_clr");
    ex(e + 1, 0, K_ERR, 8'h00, "err_cleared");
    tick(1); if0.clr_err = 1'b0;
    tick(2);
    e = edge_cnt; if0.sbar[1] = 1'b0; if0.rbar[1] = 1'b0;
    ex(e + 4, 0, K_ERR, 8'h00, "err_pre_collide");
    ex(e + 5, 0, K_ERR, 8'h02, "err_collide");
    ex(e + 6, 0, K_ERR, 8'h02, "err_collide_hold");
    ex(e + 5, 0, K_CHG, 8'h00, "m0_nochg");
    tick(4); if0.clr_err = 1'b1;
    tick(1); if0.clr_err = 1'b0;
    tick(3); if0.sbar[1] = 1'b1; if0.rbar[1] = 1'b1;
    tick(5);

    // Reset one edge before a set on channel 5 would take effect
    e = edge_cnt; if0.sbar[5] = 1'b0;
    tick(3); rst_n = 1'b0;
    ex(e + 5, 0, K_Q, 8'h00, "midrst_q");
    ex(e + 5, 0, K_ERR, 8'h00, "midrst_err");
    ex(e + 5, 4, K_Q, 8'hFF, "midrst_init1");
    tick(2); rst_n = 1'b1;
    ex(e + 7, 0, K_Q, 8'h00, "postrst_early1");
    ex(e + 9, 0, K_Q, 8'h00, "postrst_early2");
    ex(e + 10, 0, K_Q, 8'h20, "postrst_q");
    ex(e + 10, 0, K_CHG, 8'h20, "postrst_chg");
    tick(7); if0.sbar[5] = 1'b1;
    tick(5);

    // Independence: staggered sets on 0, 2, 7 then reset of 2
    e = edge_cnt; if0.sbar[0] = 1'b0;
    tick(1); if0.sbar[2] = 1'b0;
    tick(1); if0.sbar[7] = 1'b0;
    ex(e + 5, 0, K_Q, 8'h21, "ind_q0");
    ex(e + 5, 0, K_CHG, 8'h01, "ind_chg0");
    ex(e + 6, 0, K_Q, 8'h25, "ind_q2");
    ex(e + 6, 0, K_CHG, 8'h04, "ind_chg2");
    ex(e + 7, 0, K_Q, 8'hA5, "ind_q7");
    ex(e + 7, 0, K_CHG, 8'h80, "ind_chg7");
    tick(6);
    e = edge_cnt; if0.sbar = '1; if0.rbar[2] = 1'b0;
    ex(e + 4, 0, K_Q, 8'hA5, "ind_r2_early");
    ex(e + 5, 0, K_Q, 8'hA1, "ind_r2_q");
    ex(e + 5, 0, K_CHG, 8'h04, "ind_r2_chg");
    ex(e + 5, 4, K_Q, 8'hFF, "init1_untouched");
    tick(7); if0.rbar[2] = 1'b1;
    tick(3);

    for (int i = 0; i < sb.size(); i++) begin
      checks++;
      failures++;
      $display("FAIL %s never checked (due edge %0d)", sb[i].name, sb[i].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
